// File: rtl/u_type_dispatch_arbiter_if.sv
// Lane request, flush and output-slot handshake bundle for the U-type dispatch arbiter.
interface u_type_dispatch_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             flush;

  logic             req0_valid;
  logic             req0_ready;
  logic [31:0]      req0_instr;
  logic [XLEN-1:0]  req0_pc;
  logic [TAG_W-1:0] req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [31:0]      req1_instr;
  logic [XLEN-1:0]  req1_pc;
  logic [TAG_W-1:0] req1_tag;

  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rd;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_src;
  logic             out_illegal;

  modport master (
    output flush,
    output req0_valid, req0_instr, req0_pc, req0_tag,
    input  req0_ready,
    output req1_valid, req1_instr, req1_pc, req1_tag,
    input  req1_ready,
    input  out_valid, out_rd, out_result, out_tag, out_src, out_illegal,
    output out_ready
  );

  modport slave (
    input  flush,
    input  req0_valid, req0_instr, req0_pc, req0_tag,
    output req0_ready,
    input  req1_valid, req1_instr, req1_pc, req1_tag,
    output req1_ready,
    output out_valid, out_rd, out_result, out_tag, out_src, out_illegal,
    input  out_ready
  );
endinterface

// File: rtl/u_type_dispatch_arbiter.sv
// Round-robin arbiter sharing one LUI/AUIPC execute path between two fetch lanes,
// with a 1-entry output slot toward rename.
module u_type_dispatch_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  u_type_dispatch_arbiter_if.slave bus
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_e;

  slot_e            r_state;
  slot_e            w_state_nxt;
  logic             r_rr_ptr;
  logic [4:0]       r_rd;
  logic [XLEN-1:0]  r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_src;
  logic             r_illegal;

  logic             w_full;
  logic             w_can_accept;
  logic             w_grant;
  logic             w_accept;
  logic [31:0]      w_instr;
  logic [XLEN-1:0]  w_pc;
  logic [TAG_W-1:0] w_tag;
  logic signed [31:0] w_u32;
  logic [XLEN-1:0]  w_u;
  logic [XLEN-1:0]  w_result;
  logic             w_illegal;

  assign w_full       = (r_state == S_FULL);
  assign w_can_accept = !bus.flush && (!w_full || bus.out_ready);

  // A lone valid lane wins outright; contention is settled by the round-robin pointer.
  always_comb begin
    w_grant = r_rr_ptr;
    if (bus.req0_valid && !bus.req1_valid) begin
      w_grant = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign bus.req0_ready = w_can_accept && !w_grant;
  assign bus.req1_ready = w_can_accept &&  w_grant;
  assign w_accept       = w_can_accept && (w_grant ? bus.req1_valid : bus.req0_valid);

  assign w_instr = w_grant ? bus.req1_instr : bus.req0_instr;
  assign w_pc    = w_grant ? bus.req1_pc    : bus.req0_pc;
  assign w_tag   = w_grant ? bus.req1_tag   : bus.req0_tag;

  // Signed width cast sign-extends imm[31:12] to XLEN.
  assign w_u32 = {w_instr[31:12], 12'h000};
  assign w_u   = XLEN'(w_u32);

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (w_instr[6:0])
      OP_LUI:   w_result  = w_u;
      OP_AUIPC: w_result  = w_pc + w_u;
      default:  w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = S_FULL;
    end else if (w_full && bus.out_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_rr_ptr  <= 1'b0;
      r_rd      <= '0;
      r_result  <= '0;
      r_tag     <= '0;
      r_src     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rr_ptr  <= ~w_grant;
        r_rd      <= w_instr[11:7];
        r_result  <= w_result;
        r_tag     <= w_tag;
        r_src     <= w_grant;
        r_illegal <= w_illegal;
      end
    end
  end

  assign bus.out_valid   = w_full;
  assign bus.out_rd      = r_rd;
  assign bus.out_result  = r_result;
  assign bus.out_tag     = r_tag;
  assign bus.out_src     = r_src;
  assign bus.out_illegal = r_illegal;

endmodule
